// File: rtl/jam_cost_sched_if.sv
// jam_cost_sched_if: requester handshake and cost-ROM port bundle for jam_cost_sched
interface jam_cost_sched_if #(
  parameter int NREQ = 2,
  parameter int CW = 7,
  parameter int SW = 10
);
  logic [NREQ-1:0] req;
  logic [NREQ*24-1:0] perm;
  logic [NREQ-1:0] gnt;
  logic busy;
  logic [2:0] W;
  logic [2:0] J;
  logic [CW-1:0] Cost;
  logic done;
  logic [SW-1:0] sum;
  logic [1:0] sum_id;
  modport master (output req, perm, Cost, input gnt, busy, W, J, done, sum, sum_id);
  modport slave (input req, perm, Cost, output gnt, busy, W, J, done, sum, sum_id);
endinterface

// File: rtl/jam_cost_sched.sv
// jam_cost_sched: round-robin sharing of the 8x8 job-cost ROM among NREQ search engines,
// summing the eight costs of one granted assignment per evaluation.
module jam_cost_sched #(
  parameter int NREQ = 2,
  parameter int CW = 7,
  parameter int SW = 10
) (
  input logic CLK,
  input logic RST_n,
  jam_cost_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t st_q, st_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [2:0] w_q, w_d, j_q, j_d;
  logic [23:0] perm_q, perm_d;
  logic [SW-1:0] acc_q, acc_d, sum_q, sum_d;
  logic [1:0] id_q, id_d, sid_q, sid_d, last_q, last_d, pick, idx;
  logic [2:0] raw;
  logic hit, can_grant;
  logic [3:0] req4;
  logic [23:0] perm_a [4];
  logic [2:0] job [8];
  assign req4 = 4'(bus.req);
  for (genvar k = 0; k < 4; k++) begin : g_perm
    if (k < NREQ) begin : g_on
      assign perm_a[k] = bus.perm[24*k +: 24];
    end else begin : g_off
      assign perm_a[k] = '0;
    end
  end
  for (genvar k = 0; k < 8; k++) begin : g_job
    assign job[k] = perm_q[3*k +: 3];
  end
  // Scan from furthest to nearest after the last grant so the nearest requester wins.
  always_comb begin
    pick = '0;
    hit = 1'b0;
    raw = '0;
    idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      raw = 3'(last_q) + 3'(i);
      idx = 2'(raw >= 3'(NREQ) ? raw - 3'(NREQ) : raw);
      if (req4[idx]) begin
        pick = idx;
        hit = 1'b1;
      end
    end
  end
  // Outputs are registered, so the grant decision is made the cycle before gnt shows,
  // including during DRAIN so a new grant can overlap done.
  always_comb begin
    st_d = st_q;
    gnt_d = '0;
    done_d = 1'b0;
    w_d = w_q;
    j_d = j_q;
    perm_d = perm_q;
    acc_d = acc_q;
    sum_d = sum_q;
    sid_d = sid_q;
    id_d = id_q;
    last_d = last_q;
    can_grant = (st_q == IDLE && gnt_q == '0) || st_q == DRAIN;
    if (can_grant && hit) begin
      gnt_d = NREQ'(4'b0001 << pick);
      id_d = pick;
      last_d = pick;
    end
    if (st_q == IDLE && gnt_q != '0) begin
      st_d = ISSUE;
      perm_d = perm_a[id_q];
      w_d = '0;
      j_d = perm_a[id_q][2:0];
      acc_d = '0;
    end else if (st_q == ISSUE) begin
      acc_d = w_q == 3'd0 ? acc_q : acc_q + SW'(bus.Cost);
      st_d = w_q == 3'd7 ? DRAIN : ISSUE;
      w_d = w_q == 3'd7 ? 3'd0 : w_q + 3'd1;
      j_d = w_q == 3'd7 ? 3'd0 : job[w_q + 3'd1];
    end else if (st_q == DRAIN) begin
      st_d = IDLE;
      done_d = 1'b1;
      sum_d = acc_q + SW'(bus.Cost);
      sid_d = id_q;
    end
    busy_d = (gnt_d != '0) || (st_d != IDLE);
  end
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      st_q <= IDLE;
      gnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      w_q <= '0;
      j_q <= '0;
      perm_q <= '0;
      acc_q <= '0;
      sum_q <= '0;
      sid_q <= '0;
      id_q <= '0;
      last_q <= 2'(NREQ - 1);
    end else begin
      st_q <= st_d;
      gnt_q <= gnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      w_q <= w_d;
      j_q <= j_d;
      perm_q <= perm_d;
      acc_q <= acc_d;
      sum_q <= sum_d;
      sid_q <= sid_d;
      id_q <= id_d;
      last_q <= last_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.busy = busy_q;
  assign bus.W = w_q;
  assign bus.J = j_q;
  assign bus.done = done_q;
  assign bus.sum = sum_q;
  assign bus.sum_id = sid_q;
endmodule
